// File: rtl/mm2s_sched_pkg.sv
// mm2s_sched_pkg: shared types and widths for the mm2s job scheduler.
package mm2s_sched_pkg;
  localparam int MEM_W = 64;
  localparam int SIZE_W = 32;
  localparam int AXIS_ID_W = 8;
  typedef enum logic [1:0] {IDLE, START, RUN, CMPL} state_e;
  typedef struct packed {
    logic [MEM_W-1:0]     mem;
    logic [SIZE_W-1:0]    size;
    logic [AXIS_ID_W-1:0] tid;
    logic [AXIS_ID_W-1:0] tdest;
  } desc_t;
endpackage

// File: rtl/mm2s_rr_arb.sv
// mm2s_rr_arb: combinational round-robin arbiter scanning upward from ptr.
module mm2s_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  always_comb begin
    grant = '0;
    idx = '0;
    any = en & |req;
    // Scan farthest-first so the candidate closest to ptr is the last writer.
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (en && req[ID_W'((int'(ptr) + k) % NUM_REQ)]) begin
        grant = '0;
        grant[ID_W'((int'(ptr) + k) % NUM_REQ)] = 1'b1;
        idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
  end
endmodule

// File: rtl/mm2s_job_sched.sv
// mm2s_job_sched: round-robin descriptor scheduler driving one mm2s core.
module mm2s_job_sched
  import mm2s_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       ACLK_EN,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [MEM_W*NUM_REQ-1:0]   req_mem,
  input  logic [SIZE_W*NUM_REQ-1:0]  req_size,
  input  logic [AXIS_ID_W*NUM_REQ-1:0] req_tid,
  input  logic [AXIS_ID_W*NUM_REQ-1:0] req_tdest,
  output logic                       ap_start,
  input  logic                       ap_ready,
  input  logic                       ap_done,
  input  logic                       ap_idle,
  output logic [MEM_W-1:0]           mem_V,
  output logic [SIZE_W-1:0]          size_V,
  output logic [AXIS_ID_W-1:0]       tid_V,
  output logic [AXIS_ID_W-1:0]       tdest_V,
  output logic                       cmp_valid,
  input  logic                       cmp_ready,
  output logic [ID_W-1:0]            cmp_id,
  output logic                       cmp_skipped,
  output logic                       busy,
  output logic                       err_spurious
);
  state_e state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, cur_id_q, cur_id_d, gnt_idx;
  logic skip_q, skip_d, err_q, err_d, gnt_any;
  desc_t desc_q, desc_d, req_desc;
  mm2s_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(req_valid),
    .ptr(ptr_q),
    .en(ACLK_EN && ap_idle && state_q == IDLE),
    .grant(req_ready),
    .idx(gnt_idx),
    .any(gnt_any)
  );
  assign req_desc = {req_mem[int'(gnt_idx)*MEM_W +: MEM_W],
                     req_size[int'(gnt_idx)*SIZE_W +: SIZE_W],
                     req_tid[int'(gnt_idx)*AXIS_ID_W +: AXIS_ID_W],
                     req_tdest[int'(gnt_idx)*AXIS_ID_W +: AXIS_ID_W]};
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cur_id_d = cur_id_q;
    skip_d = skip_q;
    desc_d = desc_q;
    err_d = err_q | (ap_done & (state_q == IDLE || state_q == CMPL));
    unique case (state_q)
      IDLE: if (gnt_any) begin
        desc_d = req_desc;
        cur_id_d = gnt_idx;
        ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        skip_d = req_desc.size == '0;
        state_d = (req_desc.size == '0) ? CMPL : START;
      end
      // A done without ready still means the core consumed the arguments.
      START: if (ap_ready || ap_done) state_d = ap_done ? CMPL : RUN;
      RUN: if (ap_done) state_d = CMPL;
      CMPL: if (cmp_ready) begin
        state_d = IDLE;
        skip_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      ptr_q <= '0;
      cur_id_q <= '0;
      skip_q <= 1'b0;
      err_q <= 1'b0;
      desc_q <= '0;
    end else if (ACLK_EN) begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cur_id_q <= cur_id_d;
      skip_q <= skip_d;
      err_q <= err_d;
      desc_q <= desc_d;
    end
  end
  assign ap_start = state_q == START;
  assign busy = state_q != IDLE;
  assign cmp_valid = state_q == CMPL;
  assign cmp_id = cur_id_q;
  assign cmp_skipped = skip_q;
  assign err_spurious = err_q;
  assign mem_V = desc_q.mem;
  assign size_V = desc_q.size;
  assign tid_V = desc_q.tid;
  assign tdest_V = desc_q.tdest;
endmodule

// File: tb/tb_mm2s_job_sched.sv
// tb_mm2s_job_sched: randomized scoreboard bench for the mm2s job scheduler.
module tb_mm2s_job_sched;
  localparam int N = 4;
  localparam int IW = 2;
  localparam int P_IDLE = 0, P_START = 1, P_RUN = 2, P_CMPL = 3;
  logic ACLK = 1'b0, ARESET = 1'b1, ACLK_EN = 1'b1;
  logic [N-1:0] req_valid, req_ready;
  logic [64*N-1:0] req_mem;
  logic [32*N-1:0] req_size;
  logic [8*N-1:0] req_tid, req_tdest;
  logic ap_start, ap_ready, ap_done, ap_idle;
  logic [63:0] mem_V;
  logic [31:0] size_V;
  logic [7:0] tid_V, tdest_V;
  logic cmp_valid, cmp_ready, cmp_skipped, busy, err_spurious;
  logic [IW-1:0] cmp_id;
  typedef struct {int id; bit skip;} cmp_t;
  cmp_t exp_q[$];
  int n_vec = 0, n_bad = 0;
  int ph = P_IDLE, p = 0;
  bit skip = 1'b0, err = 1'b0;
  logic [63:0] m_mem = '0;
  logic [31:0] m_size = '0;
  logic [7:0] m_tid = '0, m_tdest = '0;

  mm2s_job_sched #(.NUM_REQ(N)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .ACLK_EN(ACLK_EN),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mem(req_mem), .req_size(req_size), .req_tid(req_tid), .req_tdest(req_tdest),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .mem_V(mem_V), .size_V(size_V), .tid_V(tid_V), .tdest_V(tdest_V),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_id(cmp_id),
    .cmp_skipped(cmp_skipped), .busy(busy), .err_spurious(err_spurious)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (req_valid[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Reference model: checks every cycle, then advances on the inputs the DUT samples next.
  always @(negedge ACLK) begin : model
    int g;
    logic [N-1:0] exp_rr;
    g = pick();
    exp_rr = '0;
    if (ph == P_IDLE && ap_idle && ACLK_EN && g >= 0) exp_rr[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rr));
    chk("ap_start", 64'(ap_start), 64'(ph == P_START));
    chk("busy", 64'(busy), 64'(ph != P_IDLE));
    chk("cmp_valid", 64'(cmp_valid), 64'(ph == P_CMPL));
    chk("cmp_skipped_lvl", 64'(cmp_skipped), 64'(ph == P_CMPL && skip));
    chk("err_spurious", 64'(err_spurious), 64'(err));
    chk("mem_V", mem_V, m_mem);
    chk("size_V", 64'(size_V), 64'(m_size));
    chk("tid_V", 64'(tid_V), 64'(m_tid));
    chk("tdest_V", 64'(tdest_V), 64'(m_tdest));
    if (ARESET) begin
      ph = P_IDLE; p = 0; skip = 1'b0; err = 1'b0;
      m_mem = '0; m_size = '0; m_tid = '0; m_tdest = '0;
      exp_q.delete();
    end else if (ACLK_EN) begin
      if (ap_done && (ph == P_IDLE || ph == P_CMPL)) err = 1'b1;
      case (ph)
        P_IDLE: if (ap_idle && g >= 0) begin
          m_mem = req_mem[64*g +: 64];
          m_size = req_size[32*g +: 32];
          m_tid = req_tid[8*g +: 8];
          m_tdest = req_tdest[8*g +: 8];
          p = (g + 1) % N;
          skip = (m_size == 0);
          exp_q.push_back('{g, skip});
          ph = skip ? P_CMPL : P_START;
        end
        P_START: if (ap_ready || ap_done) ph = ap_done ? P_CMPL : P_RUN;
        P_RUN: if (ap_done) ph = P_CMPL;
        default: if (cmp_ready) begin
          ph = P_IDLE;
          skip = 1'b0;
        end
      endcase
    end
  end

  always @(negedge ACLK) begin : monitor
    cmp_t e;
    if (!ARESET && ACLK_EN && cmp_valid && cmp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL cmp_unexpected: got id %0d expected no completion at %0t", cmp_id, $time);
      end else begin
        e = exp_q.pop_front();
        chk("cmp_id", 64'(cmp_id), 64'(e.id));
        chk("cmp_skipped", 64'(cmp_skipped), 64'(e.skip));
      end
    end
  end

  initial begin
    req_valid = '0; req_mem = '0; req_size = '0; req_tid = '0; req_tdest = '0;
    ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1; cmp_ready = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge ACLK);
      #1;
      ACLK_EN = ($urandom % 10) != 0;
      ARESET = (c > 2000) && ($urandom % 150) == 0;
      ap_idle = ($urandom % 8) != 0;
      for (int i = 0; i < N; i++) begin
        req_valid[i] = (c >= 600 && c < 1000) ? 1'b1 : ($urandom % 2) == 1;
        req_mem[64*i +: 64] = {$urandom, $urandom};
        req_size[32*i +: 32] = ($urandom % 4 == 0) ? 32'd0 : $urandom;
        req_tid[8*i +: 8] = 8'($urandom);
        req_tdest[8*i +: 8] = 8'($urandom);
      end
      ap_ready = ($urandom % 3) == 0;
      ap_done = (ph == P_START || ph == P_RUN) ? ($urandom % 4) == 0
                                               : (c > 1500 && ($urandom % 60) == 0);
      cmp_ready = (c >= 1000 && c < 1200) ? ($urandom % 6) == 0 : ($urandom % 2) == 1;
    end
    @(negedge ACLK);
    chk("pending_jobs", 64'(exp_q.size()), (ph == P_IDLE) ? 64'd0 : 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mm2s_job_sched.md
# mm2s_job_sched

Round-robin job scheduler that shares one mm2s core between NUM_REQ requesters. Each requester submits a descriptor (memory address, byte size, TID, TDEST). The block grants one descriptor at a time and drives the core's argument inputs and ap_start/ap_ready/ap_done handshake. It returns one completion record per job. It sits between requester logic and the mm2s core, in place of software-driven control-register writes.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, max(1, clog2(NUM_REQ)): requester index width.
- ACLK  in  1  clock; one clock domain.
- ARESET  in  1  reset, synchronous, active-high.
- ACLK_EN  in  1  clock enable; no state, pointer or flag changes while low.
- req_valid  in  NUM_REQ  per-requester descriptor valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_mem  in  64*NUM_REQ  flattened addresses; requester i uses bits [64i+63:64i].
- req_size  in  32*NUM_REQ  flattened byte counts.
- req_tid  in  8*NUM_REQ  flattened TIDs.
- req_tdest  in  8*NUM_REQ  flattened TDESTs.
- ap_start  out  1  core start.
- ap_ready  in  1  core accepted arguments.
- ap_done  in  1  core finished.
- ap_idle  in  1  core idle.
- mem_V  out  64  core argument.
- size_V  out  32  core argument.
- tid_V  out  8  core argument.
- tdest_V  out  8  core argument.
- cmp_valid  out  1  completion available.
- cmp_ready  in  1  completion consumed.
- cmp_id  out  ID_W  requester index of the completed job.
- cmp_skipped  out  1  job had size 0 and never started the core.
- busy  out  1  state is not IDLE.
- err_spurious  out  1  sticky; set by ap_done outside RUN/START.

## Operation
- FSM states: IDLE, START, RUN, CMPL. Reset state is IDLE.
- IDLE:
  - If any req_valid is set and ap_idle=1, the arbiter grants index g. Search starts at pointer p and scans upward modulo NUM_REQ.
  - req_ready[g]=1 combinationally in that cycle. The descriptor is latched into mem_V/size_V/tid_V/tdest_V and g into cur_id.
  - p is set to (g+1) mod NUM_REQ.
  - Next state is START if size≠0, otherwise CMPL with skip flag set.
- START: ap_start=1.
  - On ap_ready=1 with ap_done=0: go to RUN.
  - On ap_ready=1 with ap_done=1 (same cycle): go to CMPL.
- RUN: ap_start=0. On ap_done=1: go to CMPL.
- CMPL:
  - cmp_valid=1, cmp_id=cur_id, cmp_skipped=skip flag.
  - On cmp_ready=1: go to IDLE and clear the skip flag.
- Argument outputs hold their values from the latch until the next grant, including while in IDLE.
- req_ready is zero in every state other than IDLE, and is zero in IDLE when ap_idle=0.
- ap_done in IDLE or CMPL sets err_spurious and causes no state change. ap_done in START without ap_ready is legal and is treated as ap_ready+ap_done.
- A requester dropping req_valid before its grant is legal. It is simply skipped.

## Timing
- Reset values:
  - state IDLE, p=0, cur_id=0, skip flag 0.
  - ap_start=0, cmp_valid=0, cmp_skipped=0, busy=0, err_spurious=0, req_ready=0.
  - mem_V=0, size_V=0, tid_V=0, tdest_V=0.
- ARESET asserted mid-job returns the block to IDLE on the next edge. Any in-flight completion is lost. ARESET takes priority over ACLK_EN.
- Grant to ap_start: ap_start rises on the edge after acceptance (1 cycle).
- ap_done to completion: cmp_valid rises on the edge after ap_done is sampled.
- Zero-size job: cmp_valid rises 1 cycle after acceptance.
- Minimum job-to-job gap: one IDLE cycle after the cmp_ready handshake.
- All inputs are sampled only when ACLK_EN=1. Combinational outputs (req_ready) are additionally gated by ACLK_EN.

## Structure
- Package mm2s_sched_pkg contains:
  - the state enum (IDLE, START, RUN, CMPL);
  - the descriptor struct (mem 64, size 32, tid 8, tdest 8);
  - widths MEM_W=64, SIZE_W=32, AXIS_ID_W=8.
- Sub-module mm2s_rr_arb, parameterized NUM_REQ:
  - inputs: request vector, pointer, enable;
  - outputs: one-hot grant, binary index, any-request flag;
  - purely combinational; the pointer register lives in the parent.

## Test plan
- Single job: requester 2, mem=0x1_0000_1000, size=4096, tid=3, tdest=5. Expect ap_start one cycle after accept; args stable until ap_ready. After ap_done, expect cmp_valid one cycle later with cmp_id=2, cmp_skipped=0.
- Fairness: all four req_valid held high, core done after 10 cycles per job, 8 jobs. Expect grant order 0,1,2,3,0,1,2,3, and req_ready never asserted for two requesters at once.
- Zero size: requester 1, size=0. Expect no ap_start and cmp_valid one cycle after accept with cmp_skipped=1. Pointer advances to 2.
- Same-cycle handshake: ap_ready and ap_done together in START. Expect no RUN state and cmp_valid on the next cycle. Also hold cmp_ready=0 for 5 cycles: expect cmp_valid held and req_ready stays 0.
- Error and stall: ap_done pulsed in IDLE sets err_spurious=1 until reset. With ap_idle=0 and req_valid high, expect no grant. With ACLK_EN=0 for 3 cycles mid-RUN, expect state and outputs frozen.
- Reset mid-RUN: ARESET pulsed. Expect all outputs at reset values next cycle and the next grant starting from requester 0.
